// File: rtl/urp_pcie_dllp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : urp_pcie_dllp_pkg
// Purpose  : Shared DLLP type codes, scheduler state encoding and DLLP
//            packing helpers for the RX-side DLLP scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package urp_pcie_dllp_pkg;

  // DLLP type byte placed in bits [31:24]
  localparam logic [7:0] c_type_ack      = 8'h00;
  localparam logic [7:0] c_type_nak      = 8'h10;
  localparam logic [7:0] c_type_updfc_p  = 8'h80;
  localparam logic [7:0] c_type_updfc_np = 8'h90;
  localparam logic [7:0] c_type_updfc_cpl = 8'hA0;

  // S_IDLE: nothing presented. S_HOLD: dllp_o valid until read.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } dllp_state_e;

  function automatic logic [31:0] pack_acknak(input logic [7:0]  dllp_type,
                                              input logic [11:0] seq);
    return {dllp_type, 12'h000, seq};
  endfunction

  function automatic logic [31:0] pack_updfc(input logic [7:0]  dllp_type,
                                             input logic [7:0]  hdr,
                                             input logic [11:0] data);
    return {dllp_type, 2'b00, hdr, 2'b00, data};
  endfunction

  // Credit type index (0=P, 1=NP, 2=Cpl) to UpdateFC type byte
  function automatic logic [7:0] updfc_type(input logic [1:0] idx);
    logic [7:0] t;
    case (idx)
      2'd0:    t = c_type_updfc_p;
      2'd1:    t = c_type_updfc_np;
      default: t = c_type_updfc_cpl;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/urp_pcie_dllp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : urp_pcie_dllp_scheduler_if
// Purpose  : Bundles the RX DLL event inputs, transaction-layer credit
//            inputs and the TX-facing DLLP valid/read handshake.
// Ports    : good/dup/bad TLP events, fc_req/fc_hdr/fc_data credit info,
//            dllp_o/dllp_valid_o/dllp_read_i handshake, nak_scheduled_o.
//            master = stimulus/consumer side, slave = scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface urp_pcie_dllp_scheduler_if;
  logic             good_tlp_i;
  logic [11:0]      good_seq_i;
  logic             dup_tlp_i;
  logic             bad_tlp_i;
  logic [2:0]       fc_req_i;
  logic [2:0][7:0]  fc_hdr_i;
  logic [2:0][11:0] fc_data_i;
  logic [31:0]      dllp_o;
  logic             dllp_valid_o;
  logic             dllp_read_i;
  logic             nak_scheduled_o;

  modport master (
    output good_tlp_i, good_seq_i, dup_tlp_i, bad_tlp_i,
    output fc_req_i, fc_hdr_i, fc_data_i, dllp_read_i,
    input  dllp_o, dllp_valid_o, nak_scheduled_o
  );

  modport slave (
    input  good_tlp_i, good_seq_i, dup_tlp_i, bad_tlp_i,
    input  fc_req_i, fc_hdr_i, fc_data_i, dllp_read_i,
    output dllp_o, dllp_valid_o, nak_scheduled_o
  );
endinterface
`default_nettype wire

// File: rtl/urp_pcie_dllp_scheduler_rr_arb3.sv
`default_nettype none
// ============================================================================
// Module   : urp_pcie_rr_arb3
// Purpose  : 3-way round-robin arbiter. The request at the pointer has top
//            priority; the pointer moves to one past the winner when the
//            grant is accepted.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_req[2:0]    - requests (0=P, 1=NP, 2=Cpl)
//            i_accept      - grant consumed this cycle
//            o_gnt_idx     - index of the winning request
//            o_gnt_valid   - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module urp_pcie_rr_arb3 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [2:0] i_req,
  input  wire logic       i_accept,
  output logic      [1:0] o_gnt_idx,
  output logic            o_gnt_valid
);

  logic [1:0] r_ptr;
  logic [1:0] w_gnt_idx;
  logic       w_found;

  // (base + off) mod 3 for base, off in 0..2
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    logic [2:0] r;
    s = {1'b0, base} + {1'b0, off};
    r = (s >= 3'd3) ? (s - 3'd3) : s;
    return r[1:0];
  endfunction

  // Scan from furthest to nearest so the request closest to the pointer wins
  always_comb begin
    w_gnt_idx = 2'd0;
    w_found   = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (i_req[wrap3(r_ptr, 2'(k))]) begin
        w_gnt_idx = wrap3(r_ptr, 2'(k));
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (i_accept && w_found) begin
      r_ptr <= wrap3(w_gnt_idx, 2'd1);
    end
  end

  assign o_gnt_idx   = w_gnt_idx;
  assign o_gnt_valid = w_found;

endmodule
`default_nettype wire

// File: rtl/urp_pcie_dllp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : urp_pcie_dllp_scheduler
// Purpose  : Schedules Ack, Nak and UpdateFC DLLPs from the RX data link
//            layer toward the TX side. Acks are coalesced by a latency
//            timer, Nak_Scheduled is tracked, and all three credit types
//            are refreshed every FC_PERIOD cycles or on request.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            dllp_if    - slave modport: TLP events, credit info and the
//                         32-bit DLLP valid/read handshake
// Params   : ACK_LATENCY - max cycles an Ack is held back (>=1)
//            FC_PERIOD   - cycles between forced UpdateFC rounds (>=8)
// Revision : 1.0 - initial release
// ============================================================================
module urp_pcie_dllp_scheduler
  import urp_pcie_dllp_pkg::*;
#(
  parameter int ACK_LATENCY = 64,
  parameter int FC_PERIOD   = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  urp_pcie_dllp_scheduler_if.slave dllp_if
);

  localparam int c_ack_w = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
  localparam int c_fc_w  = $clog2(FC_PERIOD);
  localparam logic [c_ack_w-1:0] c_ack_last = c_ack_w'(ACK_LATENCY - 1);
  localparam logic [c_fc_w-1:0]  c_fc_last  = c_fc_w'(FC_PERIOD - 1);

  dllp_state_e        r_state;
  dllp_state_e        w_state_nxt;
  logic [31:0]        r_dllp;
  logic [11:0]        r_last_seq;
  logic               r_ack_pend;
  logic               r_ack_due;
  logic [c_ack_w-1:0] r_ack_cnt;
  logic               r_nak_pend;
  logic               r_nak_sched;
  logic [2:0]         r_fc_pend;
  logic [c_fc_w-1:0]  r_fc_cnt;

  logic        w_ack_due;
  logic        w_fc_any;
  logic [1:0]  w_fc_idx;
  logic        w_work;
  logic        w_load;
  logic        w_sel_nak;
  logic        w_sel_ack;
  logic        w_sel_fc;
  logic        w_ack_clr;
  logic [2:0]  w_fc_clr;
  logic        w_fc_wrap;
  logic        w_nak_sched_base;
  logic        w_nak_new;
  logic [31:0] w_next_dllp;

  // ---------------------------------------------------------------- selection
  // Dup forces immediate Ack; otherwise the Ack waits for the timer.
  assign w_ack_due = r_ack_due | (r_ack_pend && (r_ack_cnt == c_ack_last));
  assign w_work    = r_nak_pend | w_ack_due | w_fc_any;
  assign w_sel_nak = r_nak_pend;
  assign w_sel_ack = !r_nak_pend && w_ack_due;
  assign w_sel_fc  = !r_nak_pend && !w_ack_due && w_fc_any;

  // Load from IDLE, or back-to-back in HOLD when the current DLLP is read
  assign w_load = w_work && ((r_state == S_IDLE) || dllp_if.dllp_read_i);

  urp_pcie_rr_arb3 u_fc_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (r_fc_pend),
    .i_accept    (w_load && w_sel_fc),
    .o_gnt_idx   (w_fc_idx),
    .o_gnt_valid (w_fc_any)
  );

  always_comb begin
    w_next_dllp = pack_updfc(updfc_type(w_fc_idx), dllp_if.fc_hdr_i[w_fc_idx],
                             dllp_if.fc_data_i[w_fc_idx]);
    if (w_sel_nak) begin
      w_next_dllp = pack_acknak(c_type_nak, r_last_seq);
    end else if (w_sel_ack) begin
      w_next_dllp = pack_acknak(c_type_ack, r_last_seq);
    end
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_work) w_state_nxt = S_HOLD;
      S_HOLD: if (dllp_if.dllp_read_i && !w_work) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dllp <= 32'h0;
    end else if (w_load) begin
      r_dllp <= w_next_dllp;
    end
  end

  // --------------------------------------------------------- Ack / Nak state
  // A Nak acknowledges up to last_seq, so it retires a pending Ack too.
  // Set terms are OR-ed last so a same-cycle event always survives a load.
  assign w_ack_clr = w_load && (w_sel_nak || w_sel_ack);

  // A good TLP clears Nak_Scheduled before a same-cycle bad TLP is considered
  assign w_nak_sched_base = dllp_if.good_tlp_i ? 1'b0 : r_nak_sched;
  assign w_nak_new        = dllp_if.bad_tlp_i && !w_nak_sched_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_seq  <= 12'hFFF;
      r_ack_pend  <= 1'b0;
      r_ack_due   <= 1'b0;
      r_ack_cnt   <= '0;
      r_nak_pend  <= 1'b0;
      r_nak_sched <= 1'b0;
    end else begin
      if (dllp_if.good_tlp_i) begin
        r_last_seq <= dllp_if.good_seq_i;
      end
      r_ack_pend  <= (r_ack_pend && !w_ack_clr) | dllp_if.good_tlp_i | dllp_if.dup_tlp_i;
      r_ack_due   <= (r_ack_due && !w_ack_clr) | dllp_if.dup_tlp_i;
      r_nak_pend  <= (r_nak_pend && !(w_load && w_sel_nak)) | w_nak_new;
      r_nak_sched <= w_nak_sched_base | w_nak_new;
      // Timer runs from the first unacknowledged TLP and saturates at due
      if (w_ack_clr || !r_ack_pend) begin
        r_ack_cnt <= '0;
      end else if (r_ack_cnt != c_ack_last) begin
        r_ack_cnt <= r_ack_cnt + c_ack_w'(1);
      end
    end
  end

  // --------------------------------------------------------------- FC state
  assign w_fc_wrap = (r_fc_cnt == c_fc_last);
  assign w_fc_clr  = (w_load && w_sel_fc) ? (3'b001 << w_fc_idx) : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fc_cnt  <= '0;
      r_fc_pend <= 3'b000;
    end else begin
      r_fc_cnt  <= w_fc_wrap ? '0 : (r_fc_cnt + c_fc_w'(1));
      r_fc_pend <= (r_fc_pend & ~w_fc_clr) | dllp_if.fc_req_i | {3{w_fc_wrap}};
    end
  end

  assign dllp_if.dllp_o          = r_dllp;
  assign dllp_if.dllp_valid_o    = (r_state == S_HOLD);
  assign dllp_if.nak_scheduled_o = r_nak_sched;

endmodule
`default_nettype wire

// File: tb/tb_urp_pcie_dllp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_urp_pcie_dllp_scheduler
// Purpose  : Directed self-checking bench for urp_pcie_dllp_scheduler.
//            Inputs change on the falling edge; outputs are sampled there.
// Revision : 1.0 - initial release
// ============================================================================
module tb_urp_pcie_dllp_scheduler;

  localparam int ACK_LAT = 8;
  localparam int FC_PER  = 128;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  urp_pcie_dllp_scheduler_if dif ();

  urp_pcie_dllp_scheduler #(
    .ACK_LATENCY (ACK_LAT),
    .FC_PERIOD   (FC_PER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dllp_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for valid, compare {valid,dllp}, then let the read consume it
  task automatic get_dllp(input string tag, input logic [31:0] exp, input int budget);
    int n;
    n = 0;
    while (!dif.dllp_valid_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {dif.dllp_valid_o, dif.dllp_o}, {1'b1, exp});
    if (dif.dllp_valid_o) @(negedge clk);
  endtask

  // No DLLP may appear within the window
  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (dif.dllp_valid_o) seen++;
      @(negedge clk);
    end
    chk(tag, 33'(seen), 33'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dif.good_tlp_i  = 1'b0;
    dif.good_seq_i  = 12'h000;
    dif.dup_tlp_i   = 1'b0;
    dif.bad_tlp_i   = 1'b0;
    dif.fc_req_i    = 3'b000;
    dif.dllp_read_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    logic [31:0] held;
    total = 0;
    bad   = 0;
    dif.fc_hdr_i  = '0;
    dif.fc_data_i = '0;

    // ---------------- reset state
    do_reset();
    chk("rst_valid", 33'(dif.dllp_valid_o), 33'd0);
    chk("rst_dllp", 33'(dif.dllp_o), 33'd0);
    chk("rst_nak", 33'(dif.nak_scheduled_o), 33'd0);

    // ---------------- 1: single good TLP; Ack after the full latency
    dif.good_tlp_i = 1'b1;
    dif.good_seq_i = 12'h005;
    @(negedge clk);
    dif.good_tlp_i = 1'b0;
    c = 0;
    while (!dif.dllp_valid_o && c < ACK_LAT + 10) begin
      @(negedge clk);
      c++;
    end
    // sampling edge + ACK_LAT further edges = ACK_LATENCY+1 cycles
    chk("t1_latency", 33'(c), 33'(ACK_LAT));
    get_dllp("t1_ack", 32'h0000_0005, 1);
    quiet("t1_only_one", ACK_LAT + 4);

    // ---------------- 2: coalesced Acks, then dup forces immediate Ack
    do_reset();
    dif.good_tlp_i = 1'b1;
    dif.good_seq_i = 12'h005;
    @(negedge clk);
    dif.good_seq_i = 12'h006;
    @(negedge clk);
    dif.good_seq_i = 12'h007;
    @(negedge clk);
    dif.good_tlp_i = 1'b0;
    dif.dup_tlp_i  = 1'b1;
    @(negedge clk);
    dif.dup_tlp_i  = 1'b0;
    get_dllp("t2_ack_coalesced", 32'h0000_0007, 2);
    quiet("t2_single_ack", ACK_LAT + 4);

    // ---------------- 3: repeated bad TLPs give one Nak
    do_reset();
    dif.dllp_read_i = 1'b0;
    dif.bad_tlp_i   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dif.bad_tlp_i   = 1'b0;
    chk("t3_nak_flag", 33'(dif.nak_scheduled_o), 33'd1);
    chk("t3_nak_fff", {dif.dllp_valid_o, dif.dllp_o}, {1'b1, 32'h1000_0FFF});
    dif.dllp_read_i = 1'b1;
    @(negedge clk);
    quiet("t3_one_nak", ACK_LAT + 4);
    dif.good_tlp_i = 1'b1;
    dif.good_seq_i = 12'h000;
    @(negedge clk);
    dif.good_tlp_i = 1'b0;
    chk("t3_flag_clear", 33'(dif.nak_scheduled_o), 33'd0);
    dif.bad_tlp_i = 1'b1;
    @(negedge clk);
    dif.bad_tlp_i = 1'b0;
    chk("t3_flag_again", 33'(dif.nak_scheduled_o), 33'd1);
    get_dllp("t3_nak_000", 32'h1000_0000, 3);
    quiet("t3_no_ack_after_nak", ACK_LAT + 4);

    // ---------------- 4: held output stays stable, then back-to-back UpdateFC
    do_reset();
    dif.dllp_read_i = 1'b0;
    dif.fc_hdr_i    = {8'h20, 8'h20, 8'h20};
    dif.fc_data_i   = {12'h100, 12'h100, 12'h100};
    dif.fc_req_i    = 3'b111;
    @(negedge clk);
    dif.fc_req_i    = 3'b000;
    @(negedge clk);
    held = dif.dllp_o;
    chk("t4_first_p", {dif.dllp_valid_o, held}, {1'b1, 32'h8008_0100});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_stable", {dif.dllp_valid_o, dif.dllp_o}, {1'b1, 32'h8008_0100});
    end
    dif.dllp_read_i = 1'b1;
    get_dllp("t4_p", 32'h8008_0100, 1);
    get_dllp("t4_np", 32'h9008_0100, 1);
    get_dllp("t4_cpl", 32'hA008_0100, 1);
    chk("t4_idle", 33'(dif.dllp_valid_o), 33'd0);

    // ---------------- 5: Nak beats due Ack and UpdateFC; Nak retires the Ack
    do_reset();
    dif.dllp_read_i = 1'b0;
    dif.fc_hdr_i    = {8'h33, 8'h22, 8'h11};
    dif.fc_data_i   = {12'h0CD, 12'h0BC, 12'h0AB};
    dif.good_tlp_i  = 1'b1;
    dif.good_seq_i  = 12'h003;
    dif.fc_req_i    = 3'b100;
    @(negedge clk);
    dif.good_tlp_i  = 1'b0;
    dif.fc_req_i    = 3'b000;
    for (int i = 0; i < ACK_LAT + 2; i++) @(negedge clk);
    dif.bad_tlp_i   = 1'b1;
    dif.fc_req_i    = 3'b001;
    @(negedge clk);
    dif.bad_tlp_i   = 1'b0;
    dif.fc_req_i    = 3'b000;
    chk("t5_hold_cpl", {dif.dllp_valid_o, dif.dllp_o}, {1'b1, 32'hA00C_C0CD});
    dif.dllp_read_i = 1'b1;
    get_dllp("t5_cpl", 32'hA00C_C0CD, 1);
    get_dllp("t5_nak", 32'h1000_0003, 1);
    get_dllp("t5_fc_p", 32'h8004_40AB, 1);
    quiet("t5_no_ack", ACK_LAT + 4);

    // ---------------- 6: periodic UpdateFC, then reset during HOLD
    dif.fc_hdr_i  = {8'h03, 8'h02, 8'h01};
    dif.fc_data_i = {12'h033, 12'h022, 12'h011};
    do_reset();
    c = 0;
    while (!dif.dllp_valid_o && c < FC_PER + 10) begin
      @(negedge clk);
      c++;
    end
    chk("t6_period", 33'(c), 33'(FC_PER + 1));
    get_dllp("t6_p", 32'h8000_4011, 1);
    get_dllp("t6_np", 32'h9000_8022, 1);
    get_dllp("t6_cpl", 32'hA000_C033, 1);
    dif.dllp_read_i = 1'b0;
    c = 0;
    while (!dif.dllp_valid_o && c < FC_PER + 10) begin
      @(negedge clk);
      c++;
    end
    chk("t6_second_round", {dif.dllp_valid_o, dif.dllp_o}, {1'b1, 32'h8000_4011});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", 33'(dif.dllp_valid_o), 33'd0);
    chk("t6_rst_dllp", 33'(dif.dllp_o), 33'd0);
    rst = 1'b0;
    dif.dllp_read_i = 1'b1;
    quiet("t6_pending_dropped", ACK_LAT + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
